// File: rtl/loader_pkg.sv
// Shared types and helpers for the UART word loader.
package loader_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = 2;

    // Byte enables covering lanes 0..lane inclusive.
    function automatic logic [3:0] lane_mask(input logic [LANE_W-1:0] lane);
        logic [4:0] m;
        m = (5'd1 << ({3'b000, lane} + 5'd1)) - 5'd1;
        return m[3:0];
    endfunction

endpackage

// File: rtl/loader_wbuf.sv
// Single-entry valid/ready write buffer with sticky overrun when a push
// arrives while the held entry is neither empty nor being accepted.
module loader_wbuf (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  logic        i_clr,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    input  logic [3:0]  i_be,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [31:0] o_addr,
    output logic [31:0] o_data,
    output logic [3:0]  o_be,
    output logic        o_overrun
);

    logic        r_valid;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [3:0]  r_be;
    logic        r_overrun;
    logic        w_room;

    // Room exists when empty or when the held entry leaves this cycle.
    assign w_room = !r_valid || i_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_be      <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (i_push && w_room) begin
                r_valid <= 1'b1;
                r_addr  <= i_addr;
                r_data  <= i_data;
                r_be    <= i_be;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
            if (i_clr) begin
                r_overrun <= 1'b0;
            end else if (i_push && !w_room) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_addr    = r_addr;
    assign o_data    = r_data;
    assign o_be      = r_be;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_word_loader.sv
// Packs UART RX bytes into little-endian 32-bit memory writes.
// Define LOADER_CHECKSUM_EN to add the checksum/checksum_valid outputs.
module uart_word_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LEN_W     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] load_len,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             mem_wr_valid,
    input  logic             mem_wr_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wr_data,
    output logic [3:0]       mem_byte_en,
    output logic             busy,
    output logic             done,
    output logic             overrun
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [7:0]       checksum,
    output logic             checksum_valid
`endif
);

    loader_state_t     r_state, w_next;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_byte_cnt;
    logic [LANE_W-1:0] r_lane;
    logic [LEN_W-3:0]  r_word_idx;
    logic [31:0]       r_asm;

    logic              w_start, w_begin, w_byte, w_last, w_xfer;
    logic [LEN_W:0]    w_cnt_inc;
    logic [31:0]       w_word;
    logic [31:0]       w_addr;

    assign w_start   = (r_state == IDLE) && start;
    assign w_begin   = w_start && (load_len != '0);
    assign w_byte    = (r_state == LOAD) && rx_valid;
    // One bit wider than the counter so len=127 compares without wrapping.
    assign w_cnt_inc = {1'b0, r_byte_cnt} + {{LEN_W{1'b0}}, 1'b1};
    assign w_last    = (w_cnt_inc == {1'b0, r_len});
    assign w_xfer    = w_byte && ((r_lane == LANE_W'(BYTES_PER_WORD - 1)) || w_last);
    assign w_addr    = BASE_ADDR + {{(32 - LEN_W){1'b0}}, r_word_idx, 2'b00};

    always_comb begin
        w_word = r_asm;
        w_word[{r_lane, 3'b000} +: 8] = rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (load_len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                busy = 1'b1;
                if (w_byte && w_last) begin
                    w_next = FLUSH;
                end
            end
            FLUSH: begin
                busy = 1'b1;
                if (!mem_wr_valid || mem_wr_ready) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len      <= '0;
            r_byte_cnt <= '0;
            r_lane     <= '0;
            r_word_idx <= '0;
            r_asm      <= '0;
        end else if (w_begin) begin
            r_len      <= load_len;
            r_byte_cnt <= '0;
            r_lane     <= '0;
            r_word_idx <= '0;
            r_asm      <= '0;
        end else if (w_byte) begin
            r_byte_cnt <= r_byte_cnt + LEN_W'(1);
            if (w_xfer) begin
                r_lane     <= '0;
                r_asm      <= '0;
                r_word_idx <= r_word_idx + (LEN_W-2)'(1);
            end else begin
                r_lane <= r_lane + LANE_W'(1);
                r_asm  <= w_word;
            end
        end
    end

    loader_wbuf u_wbuf (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_xfer),
        .i_clr     (w_begin),
        .i_addr    (w_addr),
        .i_data    (w_word),
        .i_be      (lane_mask(r_lane)),
        .i_ready   (mem_wr_ready),
        .o_valid   (mem_wr_valid),
        .o_addr    (mem_addr),
        .o_data    (mem_wr_data),
        .o_be      (mem_byte_en),
        .o_overrun (overrun)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       r_csum_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csum     <= '0;
            r_csum_vld <= 1'b0;
        end else if (w_start) begin
            r_csum     <= '0;
            r_csum_vld <= 1'b0;
        end else begin
            if (w_byte) begin
                r_csum <= r_csum + rx_data;
            end
            if (r_state == DONE) begin
                r_csum_vld <= 1'b1;
            end
        end
    end

    assign checksum       = r_csum;
    assign checksum_valid = r_csum_vld || (r_state == DONE);
`endif

endmodule

// File: tb/tb_uart_word_loader.sv
// Scoreboard bench for uart_word_loader: directed loads, monitor-side write checking.
module tb_uart_word_loader;

    localparam logic [31:0] TB_BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  load_len;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        mem_wr_valid;
    logic        mem_wr_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_byte_en;
    logic        busy;
    logic        done;
    logic        overrun;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  checksum;
    logic        checksum_valid;
`endif

    uart_word_loader #(.BASE_ADDR(TB_BASE), .LEN_W(7)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .load_len     (load_len),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .mem_wr_valid (mem_wr_valid),
        .mem_wr_ready (mem_wr_ready),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_byte_en  (mem_byte_en),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum       (checksum),
        .checksum_valid (checksum_valid)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int acc_cyc     = -100;

    logic [67:0] exp_q[$];
    logic        h_valid = 1'b0;
    logic [67:0] h_val;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every accepted write against the scoreboard and
    // verify a stalled write stays stable.
    always @(negedge clk) begin
        if (mem_wr_valid && h_valid)
            check("hold_stable", {mem_addr, mem_wr_data, mem_byte_en}, h_val);
        if (mem_wr_valid && mem_wr_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got %0h want none",
                         {mem_addr, mem_wr_data, mem_byte_en});
            end else begin
                check("write", {mem_addr, mem_wr_data, mem_byte_en}, exp_q.pop_front());
            end
            acc_cyc = cyc;
        end
        h_valid = mem_wr_valid && !mem_wr_ready;
        h_val   = {mem_addr, mem_wr_data, mem_byte_en};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [6:0] len);
        tick();
        start    = 1'b1;
        load_len = len;
        tick();
        start    = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        exp_q.push_back({a, d, be});
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) break;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got done=0 want done=1", name);
        end else begin
            check({name, "_latency"}, 68'(cyc), 68'(acc_cyc + 1));
            @(negedge clk);
            check({name, "_pulse_len"}, 68'(done), 68'd0);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_valid"}, 68'(mem_wr_valid), 68'd0);
        check({name, "_addr"},  68'(mem_addr),     68'd0);
        check({name, "_data"},  68'(mem_wr_data),  68'd0);
        check({name, "_be"},    68'(mem_byte_en),  68'd0);
        check({name, "_busy"},  68'(busy),         68'd0);
        check({name, "_done"},  68'(done),         68'd0);
        check({name, "_ovr"},   68'(overrun),      68'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; load_len = '0;
        rx_valid = 1'b0; rx_data = '0; mem_wr_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        tick();
        rst = 1'b0;

        // Full-word load.
        push(TB_BASE + 32'h0, 32'h1413_1211, 4'hF);
        push(TB_BASE + 32'h4, 32'h1817_1615, 4'hF);
        do_start(7'd8);
        for (int b = 8'h11; b <= 8'h18; b++) send(8'(b));
        wait_done("full");
        check("full_ovr", 68'(overrun), 68'd0);
        check("full_q", 68'(exp_q.size()), 68'd0);

        // Partial tail word.
        push(TB_BASE + 32'h0, 32'hA4A3_A2A1, 4'hF);
        push(TB_BASE + 32'h4, 32'h0000_A6A5, 4'b0011);
        do_start(7'd6);
        for (int b = 8'hA1; b <= 8'hA6; b++) send(8'(b));
        wait_done("tail");
        check("tail_q", 68'(exp_q.size()), 68'd0);

        // Back-pressure: second word dropped.
        mem_wr_ready = 1'b0;
        push(TB_BASE + 32'h0, 32'h2423_2221, 4'hF);
        do_start(7'd8);
        for (int b = 8'h21; b <= 8'h28; b++) send(8'(b));
        @(negedge clk);
        check("bp_ovr", 68'(overrun), 68'd1);
        check("bp_busy", 68'(busy), 68'd1);
        check("bp_held", {mem_addr, mem_wr_data, mem_byte_en},
              {TB_BASE, 32'h2423_2221, 4'hF});
        tick();
        mem_wr_ready = 1'b1;
        wait_done("bp");
        check("bp_ovr_sticky", 68'(overrun), 68'd1);
        check("bp_q", 68'(exp_q.size()), 68'd0);

        // Zero length.
        do_start(7'd0);
        @(negedge clk);
        check("zero_done", 68'(done), 68'd1);
        check("zero_busy", 68'(busy), 68'd0);
        check("zero_valid", 68'(mem_wr_valid), 68'd0);
        @(negedge clk);
        check("zero_done_end", 68'(done), 68'd0);
        check("zero_busy2", 68'(busy), 68'd0);
        check("zero_valid2", 68'(mem_wr_valid), 68'd0);

        // Async reset mid-transfer with a pending write.
        mem_wr_ready = 1'b0;
        do_start(7'd8);
        for (int b = 8'h31; b <= 8'h35; b++) send(8'(b));
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        tick();
        rst = 1'b0;
        mem_wr_ready = 1'b1;
        push(TB_BASE, 32'h4443_4241, 4'hF);
        do_start(7'd4);
        for (int b = 8'h41; b <= 8'h44; b++) send(8'(b));
        wait_done("after_rst");
        check("after_rst_ovr", 68'(overrun), 68'd0);
        check("after_rst_q", 68'(exp_q.size()), 68'd0);

`ifdef LOADER_CHECKSUM_EN
        push(TB_BASE, 32'h2010_01FF, 4'hF);
        do_start(7'd4);
        send(8'hFF); send(8'h01); send(8'h10); send(8'h20);
        wait_done("csum");
        check("csum_value", 68'(checksum), 68'h30);
        check("csum_valid", 68'(checksum_valid), 68'd1);
`endif

        repeat (3) @(negedge clk);
        check("final_q", 68'(exp_q.size()), 68'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
